tilelink_ad_arbiter: RTL and testbench
======================================

# tilelink_ad_arbiter

Two-master to one-slave TileLink-UL arbiter for the formal-harness memory path. It shares a single A/D slave, such as the TL A-D dummy responder, between the core's master port and a second requester (e.g. a debug/DMA model). It keeps exactly one transaction outstanding, holds the grant stable on the slave A channel, counts D beats, and routes every D beat back to the owning master.

## Interface
Parameters
- XLEN, 32: data width in bits; XLEN_BYTES = XLEN/8.
- ADDR_W, 32: address width.

Ports
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_a_valid / m1_a_valid  in  1  master A request.
- m0_a_ready / m1_a_ready  out  1  master A accept.
- mN_a_bits_{opcode[2:0], param[2:0], size[3:0], source[0], address[ADDR_W], mask[XLEN_BYTES], data[XLEN]}  in  per field  master A payload.
- m0_d_valid / m1_d_valid  out  1  D beat to master.
- m0_d_ready / m1_d_ready  in  1  master D accept.
- mN_d_bits_{opcode[2:0], param[1:0], size[3:0], source, sink, data[XLEN], error}  out  per field  D payload, copied from the slave.
- s_a_valid  out  1, s_a_ready  in  1, s_a_bits_*  out: slave A channel (same fields as the master side).
- s_d_valid  in  1, s_d_ready  out  1, s_d_bits_*  in: slave D channel.
- grant_owner  out  1  current owner, for monitors.
- busy  out  1  high in A_LOCK or D_WAIT.

## Operation
- State machine: IDLE, A_LOCK, D_WAIT.
- IDLE
  - Arbitrate among asserted mN_a_valid. Choose the winner W combinationally.
  - Drive s_a_valid = mN_a_valid[W] and s_a_bits = mN_a_bits[W]. Drive mW_a_ready = s_a_ready. The loser's a_ready is 0.
  - If the A handshake fires: latch owner = W, latch the beat target, go to D_WAIT.
  - If s_a_valid = 1 and s_a_ready = 0: latch owner = W, go to A_LOCK.
- A_LOCK
  - Grant is frozen on the owner. s_a_valid and s_a_bits follow that master only. Master A stability is a protocol requirement on the master.
  - On the A handshake: go to D_WAIT.
- D_WAIT
  - All master a_ready = 0 and s_a_valid = 0.
  - Forward s_d_valid to the owner's d_valid. s_d_ready = owner's d_ready. The non-owner's d_valid = 0.
  - Each D handshake increments beat_cnt. On the last beat, go to IDLE.
- Beat target, latched at the A handshake:
  - opcode Get (4): max(1, 2^size / XLEN_BYTES) beats.
  - All other opcodes: 1 beat.
  - beat_cnt is 5 bits and saturates. Its compare uses the latched target, not s_d_bits_size.
- D traffic outside D_WAIT: s_d_valid asserted in IDLE or A_LOCK is a protocol violation. It is ignored (s_d_ready = 0) and sets sticky err_unexpected_d (internal, `(* keep *)`). Only reset clears it.
- A and D payloads pass through unmodified; source bits are not rewritten.

## Timing
- A path: zero added latency. The A handshake can complete in the same cycle the master raises valid.
- D path: zero added latency, purely combinational forwarding.
- A new grant is issued no earlier than the cycle after the last D handshake (one idle cycle of turnaround).
- Reset behaviour:
  - While reset is high: all a_ready, d_valid, s_a_valid and s_d_ready are 0; busy = 0; grant_owner = 0.
  - State returns to IDLE, beat_cnt = 0, rr_ptr = 0.
  - Reset mid-burst abandons the transaction. No D beat is forwarded in the reset cycle.
- Simultaneous requests in IDLE: the winner follows the arbitration policy (see Configuration).
- A last-beat D handshake together with a new master A valid: the new A is not accepted that cycle.

## Configuration
- TL_ARB_ROUND_ROBIN_EN
  - Defined: round-robin arbitration. rr_ptr names the preferred master and toggles to the other master after each completed transaction.
  - Undefined: fixed priority, m0 always wins. rr_ptr is removed.

## Test plan
- Single Get from m0 (size 2, XLEN 32), slave ready immediately: A fires cycle 0, one D beat (data 0xDEADBEEF) returned to m0 only, busy drops the cycle after, m1_d_valid stays 0.
- m1 Get size 4 (16 B, XLEN 32) with s_d_valid toggled randomly: exactly 4 beats forwarded to m1, then IDLE; beat 5 is never accepted.
- Both masters request in the same cycle, twice in a row:
  - With TL_ARB_ROUND_ROBIN_EN: grants are m0 then m1.
  - Without it: grants are m0 then m0, and m1 is starved until m0 deasserts.
- s_a_ready held 0 for 3 cycles while m1 newly asserts valid: grant stays on m0 (A_LOCK), and s_a_bits stay constant until the handshake.
- Reset asserted during beat 2 of a 4-beat burst: the next cycle all handshake outputs are 0 and state is IDLE; a fresh m1 Put yields exactly one D beat to m1.
- s_d_valid pulsed while IDLE: s_d_ready = 0, err_unexpected_d = 1, and no master sees d_valid.

Source files
------------

// File: rtl/tilelink_ad_arbiter.sv
// -----------------------------------------------------------------------------
// tilelink_ad_arbiter
//
// Two-master to one-slave TileLink-UL arbiter. One transaction is outstanding
// at a time: a master wins the slave A channel, the grant is frozen until the
// A beat is accepted, and then every D beat is routed back to that master
// until the expected number of beats has been seen.
//
// Configuration macro:
//   TL_ARB_ROUND_ROBIN_EN  defined   -> round-robin between m0 and m1
//                          undefined -> fixed priority, m0 always wins
//
// Ports:
//   clock, reset              sole clock (rising edge), synchronous active-high reset
//   m0_a_*, m1_a_*            master A channels (valid/ready + payload)
//   m0_d_*, m1_d_*            master D channels (valid/ready + payload)
//   s_a_*                     slave A channel (payload copied from the granted master)
//   s_d_*                     slave D channel (payload fanned out to both masters)
//   grant_owner               owner of the current/last transaction
//   busy                      high while a transaction is locked or waiting for D
// -----------------------------------------------------------------------------
module tilelink_ad_arbiter #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    localparam int XLEN_BYTES = XLEN / 8
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_a_valid,
    output logic                  m0_a_ready,
    input  logic [2:0]            m0_a_bits_opcode,
    input  logic [2:0]            m0_a_bits_param,
    input  logic [3:0]            m0_a_bits_size,
    input  logic                  m0_a_bits_source,
    input  logic [ADDR_W-1:0]     m0_a_bits_address,
    input  logic [XLEN_BYTES-1:0] m0_a_bits_mask,
    input  logic [XLEN-1:0]       m0_a_bits_data,

    input  logic                  m1_a_valid,
    output logic                  m1_a_ready,
    input  logic [2:0]            m1_a_bits_opcode,
    input  logic [2:0]            m1_a_bits_param,
    input  logic [3:0]            m1_a_bits_size,
    input  logic                  m1_a_bits_source,
    input  logic [ADDR_W-1:0]     m1_a_bits_address,
    input  logic [XLEN_BYTES-1:0] m1_a_bits_mask,
    input  logic [XLEN-1:0]       m1_a_bits_data,

    output logic                  m0_d_valid,
    input  logic                  m0_d_ready,
    output logic [2:0]            m0_d_bits_opcode,
    output logic [1:0]            m0_d_bits_param,
    output logic [3:0]            m0_d_bits_size,
    output logic                  m0_d_bits_source,
    output logic                  m0_d_bits_sink,
    output logic [XLEN-1:0]       m0_d_bits_data,
    output logic                  m0_d_bits_error,

    output logic                  m1_d_valid,
    input  logic                  m1_d_ready,
    output logic [2:0]            m1_d_bits_opcode,
    output logic [1:0]            m1_d_bits_param,
    output logic [3:0]            m1_d_bits_size,
    output logic                  m1_d_bits_source,
    output logic                  m1_d_bits_sink,
    output logic [XLEN-1:0]       m1_d_bits_data,
    output logic                  m1_d_bits_error,

    output logic                  s_a_valid,
    input  logic                  s_a_ready,
    output logic [2:0]            s_a_bits_opcode,
    output logic [2:0]            s_a_bits_param,
    output logic [3:0]            s_a_bits_size,
    output logic                  s_a_bits_source,
    output logic [ADDR_W-1:0]     s_a_bits_address,
    output logic [XLEN_BYTES-1:0] s_a_bits_mask,
    output logic [XLEN-1:0]       s_a_bits_data,

    input  logic                  s_d_valid,
    output logic                  s_d_ready,
    input  logic [2:0]            s_d_bits_opcode,
    input  logic [1:0]            s_d_bits_param,
    input  logic [3:0]            s_d_bits_size,
    input  logic                  s_d_bits_source,
    input  logic                  s_d_bits_sink,
    input  logic [XLEN-1:0]       s_d_bits_data,
    input  logic                  s_d_bits_error,

    output logic                  grant_owner,
    output logic                  busy
);

    localparam int LG_BYTES = $clog2(XLEN_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_LOCK = 2'd1,
        D_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    logic        owner_r;
    logic [4:0]  target_r;
    logic [4:0]  beat_cnt_r;
    (* keep *) logic err_unexpected_d;
`ifdef TL_ARB_ROUND_ROBIN_EN
    logic        rr_ptr_r;
`endif

    logic        win_s;
    logic        sel_s;
    logic        sel_a_valid_s;
    logic        a_open_s;
    logic        d_open_s;
    logic        a_hs_s;
    logic        d_hs_s;
    logic [4:0]  beat_inc_s;

    // Number of D beats for a request: Get returns 2^size bytes split into
    // XLEN-wide beats (at least one); everything else is a single ack.
    // The result saturates at the 5-bit counter ceiling.
    function automatic logic [4:0] beat_target(input logic [2:0] opcode,
                                               input logic [3:0] size);
        int         sh;
        logic [4:0] t;
        sh = int'(size) - LG_BYTES;
        t  = 5'd1;
        if (opcode == 3'd4 && sh > 32'sd0) begin
            if (sh >= 32'sd5) begin
                t = 5'd31;
            end else begin
                t = 5'(32'd1 << sh);
            end
        end else begin
            t = 5'd1;
        end
        return t;
    endfunction

    // Arbitration winner among the masters currently requesting.
    always_comb begin
        win_s = 1'b0;
`ifdef TL_ARB_ROUND_ROBIN_EN
        if (m0_a_valid && m1_a_valid) begin
            win_s = rr_ptr_r;
        end else if (m1_a_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        if (m0_a_valid) begin
            win_s = 1'b0;
        end else if (m1_a_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
    end

    // In IDLE the fresh winner drives the slave; afterwards the grant is frozen.
    assign sel_s         = (state_r == IDLE) ? win_s : owner_r;
    assign sel_a_valid_s = sel_s ? m1_a_valid : m0_a_valid;
    assign a_open_s      = !reset && (state_r != D_WAIT);
    assign d_open_s      = !reset && (state_r == D_WAIT);

    assign s_a_valid  = a_open_s && sel_a_valid_s;
    assign m0_a_ready = a_open_s && !sel_s && s_a_ready;
    assign m1_a_ready = a_open_s &&  sel_s && s_a_ready;

    assign s_a_bits_opcode  = sel_s ? m1_a_bits_opcode  : m0_a_bits_opcode;
    assign s_a_bits_param   = sel_s ? m1_a_bits_param   : m0_a_bits_param;
    assign s_a_bits_size    = sel_s ? m1_a_bits_size    : m0_a_bits_size;
    assign s_a_bits_source  = sel_s ? m1_a_bits_source  : m0_a_bits_source;
    assign s_a_bits_address = sel_s ? m1_a_bits_address : m0_a_bits_address;
    assign s_a_bits_mask    = sel_s ? m1_a_bits_mask    : m0_a_bits_mask;
    assign s_a_bits_data    = sel_s ? m1_a_bits_data    : m0_a_bits_data;

    // D traffic is only steered while waiting for the owner's response.
    assign m0_d_valid = d_open_s && !owner_r && s_d_valid;
    assign m1_d_valid = d_open_s &&  owner_r && s_d_valid;
    assign s_d_ready  = d_open_s && (owner_r ? m1_d_ready : m0_d_ready);

    assign m0_d_bits_opcode = s_d_bits_opcode;
    assign m0_d_bits_param  = s_d_bits_param;
    assign m0_d_bits_size   = s_d_bits_size;
    assign m0_d_bits_source = s_d_bits_source;
    assign m0_d_bits_sink   = s_d_bits_sink;
    assign m0_d_bits_data   = s_d_bits_data;
    assign m0_d_bits_error  = s_d_bits_error;
    assign m1_d_bits_opcode = s_d_bits_opcode;
    assign m1_d_bits_param  = s_d_bits_param;
    assign m1_d_bits_size   = s_d_bits_size;
    assign m1_d_bits_source = s_d_bits_source;
    assign m1_d_bits_sink   = s_d_bits_sink;
    assign m1_d_bits_data   = s_d_bits_data;
    assign m1_d_bits_error  = s_d_bits_error;

    assign a_hs_s     = s_a_valid && s_a_ready;
    assign d_hs_s     = s_d_valid && s_d_ready;
    assign beat_inc_s = (beat_cnt_r == 5'd31) ? 5'd31 : beat_cnt_r + 5'd1;

    assign grant_owner = !reset && owner_r;
    assign busy        = !reset && (state_r != IDLE);

    // Transaction state machine: grant lock, beat counting, error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= IDLE;
            owner_r          <= 1'b0;
            target_r         <= 5'd1;
            beat_cnt_r       <= 5'd0;
            err_unexpected_d <= 1'b0;
`ifdef TL_ARB_ROUND_ROBIN_EN
            rr_ptr_r         <= 1'b0;
`endif
        end else begin
            // A response with nothing outstanding is a slave protocol error.
            if (s_d_valid && (state_r != D_WAIT)) begin
                err_unexpected_d <= 1'b1;
            end else begin
                err_unexpected_d <= err_unexpected_d;
            end

            case (state_r)
                IDLE: begin
                    if (sel_a_valid_s) begin
                        owner_r <= win_s;
                        if (a_hs_s) begin
                            target_r   <= beat_target(s_a_bits_opcode, s_a_bits_size);
                            beat_cnt_r <= 5'd0;
                            state_r    <= D_WAIT;
                        end else begin
                            state_r    <= A_LOCK;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                A_LOCK: begin
                    if (a_hs_s) begin
                        target_r   <= beat_target(s_a_bits_opcode, s_a_bits_size);
                        beat_cnt_r <= 5'd0;
                        state_r    <= D_WAIT;
                    end else begin
                        state_r <= A_LOCK;
                    end
                end
                D_WAIT: begin
                    if (d_hs_s) begin
                        if (beat_inc_s >= target_r) begin
                            beat_cnt_r <= 5'd0;
                            state_r    <= IDLE;
`ifdef TL_ARB_ROUND_ROBIN_EN
                            rr_ptr_r   <= ~rr_ptr_r;
`endif
                        end else begin
                            beat_cnt_r <= beat_inc_s;
                            state_r    <= D_WAIT;
                        end
                    end else begin
                        state_r <= D_WAIT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tilelink_ad_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tilelink_ad_arbiter. Expected A grants and D beats
// are pushed to queues when stimulus is driven; a negedge monitor pops and
// compares them whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_tilelink_ad_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        m0_a_valid, m0_a_ready, m0_a_bits_source;
    logic [2:0]  m0_a_bits_opcode, m0_a_bits_param;
    logic [3:0]  m0_a_bits_size, m0_a_bits_mask;
    logic [31:0] m0_a_bits_address, m0_a_bits_data;
    logic        m1_a_valid, m1_a_ready, m1_a_bits_source;
    logic [2:0]  m1_a_bits_opcode, m1_a_bits_param;
    logic [3:0]  m1_a_bits_size, m1_a_bits_mask;
    logic [31:0] m1_a_bits_address, m1_a_bits_data;

    logic        m0_d_valid, m0_d_ready, m0_d_bits_source, m0_d_bits_sink, m0_d_bits_error;
    logic [2:0]  m0_d_bits_opcode;
    logic [1:0]  m0_d_bits_param;
    logic [3:0]  m0_d_bits_size;
    logic [31:0] m0_d_bits_data;
    logic        m1_d_valid, m1_d_ready, m1_d_bits_source, m1_d_bits_sink, m1_d_bits_error;
    logic [2:0]  m1_d_bits_opcode;
    logic [1:0]  m1_d_bits_param;
    logic [3:0]  m1_d_bits_size;
    logic [31:0] m1_d_bits_data;

    logic        s_a_valid, s_a_ready, s_a_bits_source;
    logic [2:0]  s_a_bits_opcode, s_a_bits_param;
    logic [3:0]  s_a_bits_size, s_a_bits_mask;
    logic [31:0] s_a_bits_address, s_a_bits_data;
    logic        s_d_valid, s_d_ready, s_d_bits_source, s_d_bits_sink, s_d_bits_error;
    logic [2:0]  s_d_bits_opcode;
    logic [1:0]  s_d_bits_param;
    logic [3:0]  s_d_bits_size;
    logic [31:0] s_d_bits_data;

    logic        grant_owner, busy;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    int          m0_beats = 0;
    int          m1_beats = 0;
    logic [32:0] a_q[$];
    logic [32:0] d_q[$];

    tilelink_ad_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_a_bits_opcode(m0_a_bits_opcode), .m0_a_bits_param(m0_a_bits_param),
        .m0_a_bits_size(m0_a_bits_size), .m0_a_bits_source(m0_a_bits_source),
        .m0_a_bits_address(m0_a_bits_address), .m0_a_bits_mask(m0_a_bits_mask),
        .m0_a_bits_data(m0_a_bits_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_a_bits_opcode(m1_a_bits_opcode), .m1_a_bits_param(m1_a_bits_param),
        .m1_a_bits_size(m1_a_bits_size), .m1_a_bits_source(m1_a_bits_source),
        .m1_a_bits_address(m1_a_bits_address), .m1_a_bits_mask(m1_a_bits_mask),
        .m1_a_bits_data(m1_a_bits_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m0_d_bits_opcode(m0_d_bits_opcode), .m0_d_bits_param(m0_d_bits_param),
        .m0_d_bits_size(m0_d_bits_size), .m0_d_bits_source(m0_d_bits_source),
        .m0_d_bits_sink(m0_d_bits_sink), .m0_d_bits_data(m0_d_bits_data),
        .m0_d_bits_error(m0_d_bits_error),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .m1_d_bits_opcode(m1_d_bits_opcode), .m1_d_bits_param(m1_d_bits_param),
        .m1_d_bits_size(m1_d_bits_size), .m1_d_bits_source(m1_d_bits_source),
        .m1_d_bits_sink(m1_d_bits_sink), .m1_d_bits_data(m1_d_bits_data),
        .m1_d_bits_error(m1_d_bits_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_bits_opcode(s_a_bits_opcode), .s_a_bits_param(s_a_bits_param),
        .s_a_bits_size(s_a_bits_size), .s_a_bits_source(s_a_bits_source),
        .s_a_bits_address(s_a_bits_address), .s_a_bits_mask(s_a_bits_mask),
        .s_a_bits_data(s_a_bits_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .s_d_bits_opcode(s_d_bits_opcode), .s_d_bits_param(s_d_bits_param),
        .s_d_bits_size(s_d_bits_size), .s_d_bits_source(s_d_bits_source),
        .s_d_bits_sink(s_d_bits_sink), .s_d_bits_data(s_d_bits_data),
        .s_d_bits_error(s_d_bits_error),
        .grant_owner(grant_owner), .busy(busy)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int m, input logic [2:0] op, input logic [3:0] sz,
                         input logic [31:0] addr);
        if (m == 0) begin
            m0_a_valid = 1'b1; m0_a_bits_opcode = op; m0_a_bits_size = sz;
            m0_a_bits_address = addr; m0_a_bits_data = addr ^ 32'h5555_5555;
        end else begin
            m1_a_valid = 1'b1; m1_a_bits_opcode = op; m1_a_bits_size = sz;
            m1_a_bits_address = addr; m1_a_bits_data = addr ^ 32'h5555_5555;
        end
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [31:0] data);
        s_d_valid = 1'b1; s_d_bits_opcode = op; s_d_bits_data = data;
    endtask

    // Scoreboard monitor: checks every A and D handshake against the queues.
    always @(negedge clock) begin : mon
        logic [32:0] e;
        if (s_a_valid && s_a_ready) begin
            if (a_q.size() == 0) begin
                check_val("a_unexpected", 64'd1, 64'd0);
            end else begin
                e = a_q.pop_front();
                check_val("a_owner", 64'(m1_a_ready), 64'(e[32]));
                check_val("a_ready", 64'(m0_a_ready | m1_a_ready), 64'd1);
                check_val("a_addr", 64'(s_a_bits_address), 64'(e[31:0]));
            end
        end
        if (m0_d_valid && m0_d_ready) begin
            m0_beats++;
            if (d_q.size() == 0) begin
                check_val("d0_unexpected", 64'd1, 64'd0);
            end else begin
                e = d_q.pop_front();
                check_val("d0_owner", 64'd0, 64'(e[32]));
                check_val("d0_data", 64'(m0_d_bits_data), 64'(e[31:0]));
            end
        end
        if (m1_d_valid && m1_d_ready) begin
            m1_beats++;
            if (d_q.size() == 0) begin
                check_val("d1_unexpected", 64'd1, 64'd0);
            end else begin
                e = d_q.pop_front();
                check_val("d1_owner", 64'd1, 64'(e[32]));
                check_val("d1_data", 64'(m1_d_bits_data), 64'(e[31:0]));
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int sent;
        int start;
        logic w2;
        logic w3;

        reset = 1'b1;
        m0_a_valid = 1'b0; m0_a_bits_opcode = 3'd0; m0_a_bits_param = 3'd0; m0_a_bits_size = 4'd0;
        m0_a_bits_source = 1'b0; m0_a_bits_address = 32'd0; m0_a_bits_mask = 4'hF; m0_a_bits_data = 32'd0;
        m1_a_valid = 1'b0; m1_a_bits_opcode = 3'd0; m1_a_bits_param = 3'd0; m1_a_bits_size = 4'd0;
        m1_a_bits_source = 1'b1; m1_a_bits_address = 32'd0; m1_a_bits_mask = 4'hF; m1_a_bits_data = 32'd0;
        m0_d_ready = 1'b1; m1_d_ready = 1'b1;
        s_a_ready = 1'b1;
        s_d_valid = 1'b1; s_d_bits_opcode = 3'd1; s_d_bits_param = 2'd0; s_d_bits_size = 4'd2;
        s_d_bits_source = 1'b0; s_d_bits_sink = 1'b0; s_d_bits_data = 32'd0; s_d_bits_error = 1'b0;
        m0_a_valid = 1'b1;

        // Reset: every handshake output held low despite active inputs.
        #1;
        check_val("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
        check_val("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        check_val("rst_s_d_ready", 64'(s_d_ready), 64'd0);
        check_val("rst_m0_d_valid", 64'(m0_d_valid | m1_d_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_owner", 64'(grant_owner), 64'd0);
        step(); step();
        reset = 1'b0; m0_a_valid = 1'b0; s_a_ready = 1'b0; s_d_valid = 1'b0;
        step();

        // Test 1: single Get from m0, slave ready at once.
        set_a(0, 3'd4, 4'd2, 32'h0000_1000); s_a_ready = 1'b1;
        a_q.push_back({1'b0, 32'h0000_1000});
        #1;
        check_val("t1_m0_a_ready", 64'(m0_a_ready), 64'd1);
        check_val("t1_m1_a_ready", 64'(m1_a_ready), 64'd0);
        step();
        m0_a_valid = 1'b0; s_a_ready = 1'b0;
        d_beat(3'd1, 32'hDEAD_BEEF); d_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_m1_d_valid", 64'(m1_d_valid), 64'd0);
        check_val("t1_s_d_ready", 64'(s_d_ready), 64'd1);
        step();
        s_d_valid = 1'b0;
        #1;
        check_val("t1_busy_drop", 64'(busy), 64'd0);

        // Test 2: m1 Get of 16 bytes, slave D valid toggling randomly.
        step();
        set_a(1, 3'd4, 4'd4, 32'h0000_2000); s_a_ready = 1'b1;
        a_q.push_back({1'b1, 32'h0000_2000});
        step();
        m1_a_valid = 1'b0; s_a_ready = 1'b1;
        set_a(0, 3'd4, 4'd2, 32'h0000_3000);
        #1;
        check_val("t2_dwait_s_a_valid", 64'(s_a_valid), 64'd0);
        check_val("t2_dwait_m0_a_ready", 64'(m0_a_ready), 64'd0);
        check_val("t2_owner", 64'(grant_owner), 64'd1);
        step();
        m0_a_valid = 1'b0; s_a_ready = 1'b0;
        start = m1_beats;
        sent = 0;
        for (int c = 0; c < 64 && sent < 4; c++) begin
            s_d_valid = 1'($urandom_range(0, 1));
            s_d_bits_opcode = 3'd1;
            s_d_bits_data = 32'hA000_0000 + 32'(sent);
            if (s_d_valid) begin
                d_q.push_back({1'b1, s_d_bits_data});
                sent++;
            end
            step();
        end
        check_val("t2_burst_sent", 64'(sent), 64'd4);
        d_beat(3'd1, 32'hA000_0004);
        #1;
        check_val("t2_beat5_ready", 64'(s_d_ready), 64'd0);
        check_val("t2_beat5_valid", 64'(m1_d_valid), 64'd0);
        check_val("t2_busy", 64'(busy), 64'd0);
        step();
        s_d_valid = 1'b0;
        check_val("t2_m1_beats", 64'(m1_beats - start), 64'd4);

        // Test 3: simultaneous requests, twice, then the other master.
`ifdef TL_ARB_ROUND_ROBIN_EN
        w2 = 1'b1;
`else
        w2 = 1'b0;
`endif
        w3 = ~w2;
        set_a(0, 3'd0, 4'd2, 32'h0000_0A00);
        set_a(1, 3'd0, 4'd2, 32'h0000_0B00);
        s_a_ready = 1'b1;
        a_q.push_back({1'b0, 32'h0000_0A00});
        #1;
        check_val("t3_g1_m1_a_ready", 64'(m1_a_ready), 64'd0);
        step();
        set_a(0, 3'd0, 4'd2, 32'h0000_0A04);
        d_beat(3'd0, 32'h0000_00C1); d_q.push_back({1'b0, 32'h0000_00C1});
        #1;
        check_val("t3_dwait_a_ready", 64'(m0_a_ready | m1_a_ready), 64'd0);
        check_val("t3_dwait_s_a_valid", 64'(s_a_valid), 64'd0);
        step();
        s_d_valid = 1'b0;
        a_q.push_back({w2, w2 ? 32'h0000_0B00 : 32'h0000_0A04});
        step();
        if (w2) m1_a_valid = 1'b0; else m0_a_valid = 1'b0;
        d_beat(3'd0, 32'h0000_00C2); d_q.push_back({w2, 32'h0000_00C2});
        #1;
        check_val("t3_g2_owner", 64'(grant_owner), 64'(w2));
        step();
        s_d_valid = 1'b0;
        a_q.push_back({w3, w3 ? 32'h0000_0B00 : 32'h0000_0A04});
        step();
        m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_a_ready = 1'b0;
        d_beat(3'd0, 32'h0000_00C3); d_q.push_back({w3, 32'h0000_00C3});
        #1;
        check_val("t3_g3_owner", 64'(grant_owner), 64'(w3));
        step();
        s_d_valid = 1'b0;
        step();

        // Test 4: slave stalls A for three cycles while m1 starts requesting.
        set_a(0, 3'd4, 4'd2, 32'h0000_4000);
        step();
        set_a(1, 3'd4, 4'd2, 32'h0000_5000);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val("t4_lock_addr", 64'(s_a_bits_address), 64'h4000);
            check_val("t4_lock_valid", 64'(s_a_valid), 64'd1);
            check_val("t4_lock_m1_ready", 64'(m1_a_ready), 64'd0);
            check_val("t4_lock_owner", 64'(grant_owner), 64'd0);
            check_val("t4_lock_busy", 64'(busy), 64'd1);
            step();
        end
        s_a_ready = 1'b1;
        a_q.push_back({1'b0, 32'h0000_4000});
        step();
        m0_a_valid = 1'b0; m1_a_valid = 1'b0; s_a_ready = 1'b0;
        d_beat(3'd1, 32'h0000_4444); d_q.push_back({1'b0, 32'h0000_4444});
        step();
        s_d_valid = 1'b0;
        step();

        // Test 5: reset lands on beat 2 of a 4-beat burst.
        set_a(0, 3'd4, 4'd4, 32'h0000_6000); s_a_ready = 1'b1;
        a_q.push_back({1'b0, 32'h0000_6000});
        step();
        m0_a_valid = 1'b0; s_a_ready = 1'b0;
        d_beat(3'd1, 32'h0000_B000); d_q.push_back({1'b0, 32'h0000_B000});
        step();
        d_beat(3'd1, 32'h0000_B001);
        reset = 1'b1;
        #1;
        check_val("t5_rst_d_valid", 64'(m0_d_valid), 64'd0);
        check_val("t5_rst_s_d_ready", 64'(s_d_ready), 64'd0);
        check_val("t5_rst_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0; s_d_valid = 1'b0;
        #1;
        check_val("t5_post_busy", 64'(busy), 64'd0);
        check_val("t5_post_a_ready", 64'(m0_a_ready | m1_a_ready), 64'd0);
        check_val("t5_post_s_a_valid", 64'(s_a_valid), 64'd0);
        check_val("t5_post_err", 64'(dut.err_unexpected_d), 64'd0);
        set_a(1, 3'd0, 4'd2, 32'h0000_7000); s_a_ready = 1'b1;
        a_q.push_back({1'b1, 32'h0000_7000});
        step();
        m1_a_valid = 1'b0; s_a_ready = 1'b0;
        start = m1_beats;
        d_beat(3'd0, 32'h0000_7777); s_d_bits_source = 1'b1;
        d_q.push_back({1'b1, 32'h0000_7777});
        #1;
        check_val("t5_d_source", 64'(m1_d_bits_source), 64'd1);
        step();
        s_d_valid = 1'b0; s_d_bits_source = 1'b0;
        #1;
        check_val("t5_put_busy", 64'(busy), 64'd0);
        check_val("t5_m1_beats", 64'(m1_beats - start), 64'd1);

        // Test 6: stray D beat while IDLE.
        step();
        d_beat(3'd1, 32'h0000_EEEE);
        #1;
        check_val("t6_s_d_ready", 64'(s_d_ready), 64'd0);
        check_val("t6_d_valid", 64'(m0_d_valid | m1_d_valid), 64'd0);
        step();
        s_d_valid = 1'b0;
        check_val("t6_err_sticky", 64'(dut.err_unexpected_d), 64'd1);
        step();
        check_val("t6_err_held", 64'(dut.err_unexpected_d), 64'd1);

        check_val("a_q_empty", 64'(a_q.size()), 64'd0);
        check_val("d_q_empty", 64'(d_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
